// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package instruction_fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    // Instruction shown to decode whenever no fetched instruction is valid.
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'b0000100000000000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Two-deep FIFO of fetched {pc, instr} entries with flush; head is read from registers.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entries_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;

    // Each slot captures the pushed entry when the write pointer selects it.
    // When full, push+pop overwrites the head slot that is leaving this cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entries_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    entries_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = entries_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, buffers fetched words and presents them to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0]    PC_STEP  = 16'd4,
    parameter logic [INSTR_W-1:0] NOP_WORD = instruction_fetch_unit_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               mem_conflict_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [PC_W-1:0]    id_pc_o,
    input  logic               id_ready_i,
    output logic [15:0]        stall_cnt_o
);

    fetch_state_t    state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     stall_cnt_reg;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [1:0]   count;
    logic         id_valid;
    logic         pop;
    logic         space;
    logic         push;
    logic         stall;

    // Fetch decision: redirect pre-empts everything; otherwise fetch when there
    // is room (possibly made by this cycle's pop) and memory is free, else stall.
    always_comb begin
        id_valid   = (count != 2'd0);
        pop        = id_valid && id_ready_i && !redirect_i;
        space      = (count < 2'd2) || (id_valid && id_ready_i);
        push       = (state_reg == RUN) && !redirect_i && space && !mem_conflict_i;
        stall      = (state_reg == RUN) && !redirect_i && !(space && !mem_conflict_i);
        push_entry = '{pc: pc_reg, instr: instr_i};
    end

    // BOOT gives memory a single load cycle; a redirect there still moves the PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            stall_cnt_reg <= 16'd0;
        end else begin
            state_reg <= RUN;
            if (redirect_i) begin
                pc_reg <= redirect_pc_i;
            end else if (push) begin
                pc_reg <= pc_reg + PC_STEP;
            end
            if (stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_i),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign pc_o        = pc_reg;
    assign id_valid_o  = id_valid;
    assign id_instr_o  = id_valid ? head.instr : NOP_WORD;
    assign id_pc_o     = id_valid ? head.pc : '0;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a pc-indexed memory model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_o;
    logic [15:0] instr_i;
    logic        mem_conflict_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = 16'h0000;
    logic        id_valid_o;
    logic [15:0] id_instr_o;
    logic [15:0] id_pc_o;
    logic        id_ready_i = 1'b1;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] NOP = 16'b0000100000000000;

    // Memory contents: word at index pc>>2 is {A, index[11:0]}.
    function automatic logic [15:0] word(input logic [15:0] a);
        return {4'hA, a[13:2]};
    endfunction

    assign instr_i = word(pc_o);

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_o           (pc_o),
        .instr_i        (instr_i),
        .mem_conflict_i (mem_conflict_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .id_valid_o     (id_valid_o),
        .id_instr_o     (id_instr_o),
        .id_pc_o        (id_pc_o),
        .id_ready_i     (id_ready_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h v=%b id_pc=%h id_instr=%h stall=%0d",
                 $time, pc_o, id_valid_o, id_pc_o, id_instr_o, stall_cnt_o);
    endtask

    // Hold reset across one edge, release it; the next edge is the BOOT edge.
    task automatic start;
        rst = 1'b1; redirect_i = 1'b0; mem_conflict_i = 1'b0; id_ready_i = 1'b1;
        redirect_pc_i = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (pc_o !== 16'h0000) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, 16'h0000); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", id_valid_o); end
        n_cmp++; if (id_instr_o !== NOP) begin n_bad++; $display("FAIL rst_instr got=%h exp=%h", id_instr_o, NOP); end
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL rst_idpc got=%h exp=0000", id_pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'h0000) begin n_bad++; $display("FAIL rst_stall got=%h exp=0000", stall_cnt_o); end
    endtask

    task automatic test_stream;
        start();
        tick(); // BOOT edge: no fetch
        n_cmp++; if (pc_o !== 16'h0000) begin n_bad++; $display("FAIL boot_pc got=%h exp=0000", pc_o); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL boot_valid got=%b exp=0", id_valid_o); end
        tick();
        n_cmp++; if (pc_o !== 16'h0004) begin n_bad++; $display("FAIL s_pc1 got=%h exp=0004", pc_o); end
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL s_idpc1 got=%h exp=0000", id_pc_o); end
        n_cmp++; if (id_instr_o !== word(16'h0000)) begin n_bad++; $display("FAIL s_instr1 got=%h exp=%h", id_instr_o, word(16'h0000)); end
        tick();
        n_cmp++; if (pc_o !== 16'h0008) begin n_bad++; $display("FAIL s_pc2 got=%h exp=0008", pc_o); end
        n_cmp++; if (id_pc_o !== 16'h0004) begin n_bad++; $display("FAIL s_idpc2 got=%h exp=0004", id_pc_o); end
        // Back-to-back: one instruction per cycle, in order.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_pc;
            tick();
            exp_pc = 16'(16'h0008 + 4 * i);
            n_cmp++; if (id_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, id_valid_o); end
            n_cmp++; if (id_pc_o !== exp_pc) begin n_bad++; $display("FAIL b2b_idpc[%0d] got=%h exp=%h", i, id_pc_o, exp_pc); end
            n_cmp++; if (id_instr_o !== word(exp_pc)) begin n_bad++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, id_instr_o, word(exp_pc)); end
        end
    endtask

    task automatic test_backpressure;
        start();
        tick(); // BOOT
        id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (pc_o !== 16'h0008) begin n_bad++; $display("FAIL bp_pc got=%h exp=0008", pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'd3) begin n_bad++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt_o); end
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL bp_head got=%h exp=0000", id_pc_o); end
        id_ready_i = 1'b1;
        tick();
        n_cmp++; if (id_pc_o !== 16'h0004) begin n_bad++; $display("FAIL bp_pop1 got=%h exp=0004", id_pc_o); end
        n_cmp++; if (pc_o !== 16'h000C) begin n_bad++; $display("FAIL bp_pc2 got=%h exp=000C", pc_o); end
        tick();
        n_cmp++; if (id_pc_o !== 16'h0008) begin n_bad++; $display("FAIL bp_pop2 got=%h exp=0008", id_pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'd3) begin n_bad++; $display("FAIL bp_stall2 got=%0d exp=3", stall_cnt_o); end
    endtask

    task automatic test_conflict;
        start();
        tick(); // BOOT
        tick(); tick(); tick();
        n_cmp++; if (pc_o !== 16'h000C) begin n_bad++; $display("FAIL cf_pc0 got=%h exp=000C", pc_o); end
        mem_conflict_i = 1'b1;
        tick(); tick();
        n_cmp++; if (pc_o !== 16'h000C) begin n_bad++; $display("FAIL cf_pc got=%h exp=000C", pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'd2) begin n_bad++; $display("FAIL cf_stall got=%0d exp=2", stall_cnt_o); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL cf_valid got=%b exp=0", id_valid_o); end
        mem_conflict_i = 1'b0;
        tick();
        n_cmp++; if (id_pc_o !== 16'h000C) begin n_bad++; $display("FAIL cf_resume got=%h exp=000C", id_pc_o); end
        n_cmp++; if (id_instr_o !== word(16'h000C)) begin n_bad++; $display("FAIL cf_instr got=%h exp=%h", id_instr_o, word(16'h000C)); end
        n_cmp++; if (pc_o !== 16'h0010) begin n_bad++; $display("FAIL cf_pc2 got=%h exp=0010", pc_o); end
    endtask

    task automatic test_redirect;
        start();
        tick(); // BOOT
        id_ready_i = 1'b0;
        tick(); tick(); // queue full
        id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0050;
        tick();
        redirect_i = 1'b0;
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_valid got=%b exp=0", id_valid_o); end
        n_cmp++; if (id_instr_o !== NOP) begin n_bad++; $display("FAIL rd_nop got=%h exp=%h", id_instr_o, NOP); end
        n_cmp++; if (pc_o !== 16'h0050) begin n_bad++; $display("FAIL rd_pc got=%h exp=0050", pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rd_stall got=%0d exp=0", stall_cnt_o); end
        tick();
        n_cmp++; if (id_pc_o !== 16'h0050) begin n_bad++; $display("FAIL rd_idpc got=%h exp=0050", id_pc_o); end
        n_cmp++; if (pc_o !== 16'h0054) begin n_bad++; $display("FAIL rd_pc2 got=%h exp=0054", pc_o); end
    endtask

    task automatic test_wrap;
        start();
        redirect_i = 1'b1; redirect_pc_i = 16'hFFFC; // redirect on the BOOT edge
        tick();
        redirect_i = 1'b0;
        n_cmp++; if (pc_o !== 16'hFFFC) begin n_bad++; $display("FAIL wr_bootpc got=%h exp=FFFC", pc_o); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL wr_bootvalid got=%b exp=0", id_valid_o); end
        tick();
        n_cmp++; if (pc_o !== 16'h0000) begin n_bad++; $display("FAIL wr_pc got=%h exp=0000", pc_o); end
        n_cmp++; if (id_pc_o !== 16'hFFFC) begin n_bad++; $display("FAIL wr_idpc got=%h exp=FFFC", id_pc_o); end
        n_cmp++; if (id_instr_o !== word(16'hFFFC)) begin n_bad++; $display("FAIL wr_instr got=%h exp=%h", id_instr_o, word(16'hFFFC)); end
        tick();
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL wr_idpc2 got=%h exp=0000", id_pc_o); end
    endtask

    task automatic test_async_reset;
        start();
        tick(); // BOOT
        id_ready_i = 1'b0;
        tick(); tick(); tick(); // full, one stall
        n_cmp++; if (stall_cnt_o !== 16'd1) begin n_bad++; $display("FAIL ar_pre_stall got=%0d exp=1", stall_cnt_o); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (pc_o !== 16'h0000) begin n_bad++; $display("FAIL ar_pc got=%h exp=0000", pc_o); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_valid got=%b exp=0", id_valid_o); end
        n_cmp++; if (id_instr_o !== NOP) begin n_bad++; $display("FAIL ar_instr got=%h exp=%h", id_instr_o, NOP); end
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL ar_idpc got=%h exp=0000", id_pc_o); end
        n_cmp++; if (stall_cnt_o !== 16'd0) begin n_bad++; $display("FAIL ar_stall got=%0d exp=0", stall_cnt_o); end
        @(posedge clk);
        #1;
        rst = 1'b0; id_ready_i = 1'b1;
        tick(); // BOOT
        n_cmp++; if (pc_o !== 16'h0000) begin n_bad++; $display("FAIL ar_boot_pc got=%h exp=0000", pc_o); end
        n_cmp++; if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL ar_boot_valid got=%b exp=0", id_valid_o); end
        tick();
        n_cmp++; if (id_pc_o !== 16'h0000) begin n_bad++; $display("FAIL ar_first got=%h exp=0000", id_pc_o); end
        n_cmp++; if (pc_o !== 16'h0004) begin n_bad++; $display("FAIL ar_pc2 got=%h exp=0004", pc_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_conflict();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
